// File: rtl/riscv_pkg.sv
// Shared RV32 constants used by the fetch and decode stages.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_BRANCH = 7'b1100011
  } opcodeE;

endpackage

// File: rtl/fetch_buffer.sv
// Small power-of-two FIFO holding {pc, instr} pairs between fetch and decode.
module fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  // Pop frees the head slot, so a push into a full buffer is legal in the same cycle.
  always_comb begin
    doPop  = pop & (count != '0);
    doPush = push & ((count != FULL_COUNT) | doPop);
  end

  assign headData = mem[rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single outstanding imem request, buffered delivery to decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned          XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC  = riscv_pkg::RESET_PC,
  parameter int unsigned          BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = BUF_DEPTH[CW:0];

  logic [XLEN-1:0]   pcQ;
  logic [XLEN-1:0]   reqPcQ;
  logic              inflightQ;
  logic [XLEN-1:0]   issueAddr;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;
  logic              bufEmpty;
  logic              rspAccept;
  logic              pop;
  logic              bufPush;
  logic              bufPop;
  logic [CW:0]       occupancy;
  logic              issue;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (bufPush),
    .pushData ({reqPcQ, imem_rsp_data}),
    .pop      (bufPop),
    .flush    (redirect_valid),
    .headData (head),
    .count    (count)
  );

  // An accepted response bypasses an empty buffer so decode sees it the cycle it arrives;
  // if decode does not take it, it is queued and reappears unchanged from the buffer head.
  always_comb begin
    bufEmpty  = (count == '0);
    rspAccept = imem_rsp_valid & inflightQ & ~redirect_valid;
    if_valid  = ~redirect_valid & (~bufEmpty | rspAccept);
    pop       = if_valid & if_ready;
    bufPop    = pop & ~bufEmpty;
    bufPush   = rspAccept & ~(bufEmpty & pop);
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflightQ} - {{CW{1'b0}}, pop};
    issue     = rst & (redirect_valid | (occupancy < DEPTH_LIM));
    issueAddr = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : pcQ;
    if (!bufEmpty) begin
      if_pc    = head[2*XLEN-1:XLEN];
      if_instr = head[XLEN-1:0];
    end else if (rspAccept) begin
      if_pc    = reqPcQ;
      if_instr = imem_rsp_data;
    end else begin
      if_pc    = '0;
      if_instr = '0;
    end
  end

  assign imem_req_valid = issue;
  assign imem_req_addr  = issueAddr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcQ       <= RESET_PC;
      reqPcQ    <= '0;
      inflightQ <= 1'b0;
    end else begin
      inflightQ <= issue;
      if (issue) begin
        reqPcQ <= issueAddr;
        pcQ    <= issueAddr + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the imem stand-in returns each request address as its data.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; the request seen before the edge is answered one cycle later.
  task automatic cycle();
    logic        reqV;
    logic [31:0] reqA;
    reqV = imem_req_valid;
    reqA = imem_req_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = reqV;
    imem_rsp_data  = reqA;
    #1;
  endtask

  task automatic chkHead(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, pc);
  endtask

  task automatic chkReq(input string tag, input logic v, input logic [31:0] addr);
    chk({tag, "_reqv"}, {31'b0, imem_req_valid}, {31'b0, v});
    if (v) chk({tag, "_addr"}, imem_req_addr, addr);
  endtask

  initial begin
    // Reset held
    #3;
    chkReq("rst", 1'b0, 32'h0);
    chk("rst_ifv", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);

    // Release between edges: first request immediately
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chkReq("c0", 1'b1, 32'h0);
    chk("c0_ifv", {31'b0, if_valid}, 32'd0);

    // Full-rate streaming
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chkHead("stream", 32'(4 * (i - 1)));
      chkReq("stream", 1'b1, 32'(4 * i));
    end

    // Decode stalls for 5 cycles: head 16 held, buffer fills, requests stop
    if_ready = 1'b0;
    #1;
    chkReq("stall0", 1'b1, 32'd20);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chkHead("stall", 32'd16);
      chkReq("stall", 1'b0, 32'h0);
    end

    // Drain in order
    cycle();
    if_ready = 1'b1;
    #1;
    chkHead("drain0", 32'd16);
    chkReq("drain0", 1'b1, 32'd24);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chkHead("drain", 32'(16 + 4 * i));
      chkReq("drain", 1'b1, 32'(24 + 4 * i));
    end

    // Stall with one buffered entry and a response in flight, then redirect
    if_ready = 1'b0;
    #1;
    cycle();
    chkHead("prered", 32'd28);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("red_ifv", {31'b0, if_valid}, 32'd0);
    chkReq("red", 1'b1, 32'h100);
    cycle();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    #1;
    chkHead("red1", 32'h100);
    chkReq("red1", 1'b1, 32'h104);
    cycle();
    chkHead("red2", 32'h104);

    // Misaligned target is word-aligned
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    #1;
    chk("mis_ifv", {31'b0, if_valid}, 32'd0);
    chkReq("mis", 1'b1, 32'h200);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chkHead("mis1", 32'h200);
    chkReq("mis1", 1'b1, 32'h204);
    cycle();
    chkHead("mis2", 32'h204);

    // PC wraps modulo 2^32
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    #1;
    chkReq("wrap0", 1'b1, 32'hFFFF_FFF8);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chkHead("wrap1", 32'hFFFF_FFF8);
    chkReq("wrap1", 1'b1, 32'hFFFF_FFFC);
    cycle();
    chkHead("wrap2", 32'hFFFF_FFFC);
    chkReq("wrap2", 1'b1, 32'h0);
    cycle();
    chkHead("wrap3", 32'h0);
    chkReq("wrap3", 1'b1, 32'h4);

    // Back-to-back redirects: only the last target survives
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    chkReq("b2b0", 1'b1, 32'h300);
    cycle();
    redirect_pc = 32'h400;
    #1;
    chk("b2b1_ifv", {31'b0, if_valid}, 32'd0);
    chkReq("b2b1", 1'b1, 32'h400);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chkHead("b2b2", 32'h400);

    // Fill the buffer, then assert reset mid-stream
    if_ready = 1'b0;
    #1;
    cycle();
    chkHead("fill1", 32'h400);
    cycle();
    chkHead("fill2", 32'h400);
    chkReq("fill2", 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    chkReq("mrst", 1'b0, 32'h0);
    chk("mrst_ifv", {31'b0, if_valid}, 32'd0);
    chk("mrst_instr", if_instr, 32'h0);
    chk("mrst_pc", if_pc, 32'h0);
    cycle();
    rst      = 1'b1;
    if_ready = 1'b1;
    #1;
    chkReq("rel0", 1'b1, 32'h0);
    chk("rel0_ifv", {31'b0, if_valid}, 32'd0);
    cycle();
    chkHead("rel1", 32'h0);
    chkReq("rel1", 1'b1, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
